alu_muldiv_sequencer: RTL and testbench
=======================================

// Module: alu_muldiv_sequencer
// PURPOSE
//  Multi-cycle sequencer that computes MUL (low 32), DIVU and REMU by issuing
//  one op per cycle to the shared 32-bit ALU (codes 0010 add, 0110 sub,
//  1001 sltu). Sits beside the core datapath, borrows the ALU through a
//  req/gnt pair, and returns the result with a one-cycle done pulse.
// PARAMETERS
//  WIDTH  32  operand/result width; only 32 is supported (counter is 5 bits)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   launch request; sampled only in IDLE
//  op         in   2   00 MUL, 01 DIVU, 10 REMU, 11 reserved
//  opa        in   32  multiplicand / dividend, captured on accepted start
//  opb        in   32  multiplier / divisor, captured on accepted start
//  busy       out  1   high from the cycle after accept until done
//  done       out  1   one-cycle pulse, result valid
//  result     out  32  final value, held until the next accepted start
//  alu_req    out  1   high in MUL, DIV_CMP and DIV_SUB
//  alu_gnt    in   1   ALU granted this cycle; the state holds while low
//  alu_a      out  32  ALU operand A
//  alu_b      out  32  ALU operand B
//  alu_op     out  4   ALU_operation code
//  alu_res    in   32  ALU res, combinational, same cycle
// BEHAVIOUR
//  Reset:
//   - state=IDLE; busy=done=alu_req=0; result=0; cnt=0.
//   - alu_a=alu_b=0 and alu_op=4'b0010 whenever alu_req=0.
//  States: IDLE, MUL, DIV_CMP, DIV_SUB, DONE.
//  IDLE + start:
//   - Capture opa and opb.
//   - op=00 -> MUL: acc=0, mcand=opa, mplier=opb.
//   - op=01/10 with opb!=0 -> DIV_CMP: rem=0, quo=opa, dvs=opb.
//   - op=01/10 with opb==0 -> DONE, no ALU use. DIVU gives 0xFFFFFFFF;
//     REMU gives opa.
//   - op=11 -> DONE with result 0.
//  start is ignored when the state is not IDLE.
//  MUL, per cycle with alu_gnt=1:
//   - Drive alu_a=acc, alu_b=mcand, alu_op=0010.
//   - If mplier[0]=1, acc<=alu_res.
//   - mcand<<=1, mplier>>=1, cnt++.
//   - After cnt==31 -> DONE. Exactly 32 granted cycles; sum wraps mod 2^32.
//  Division, trial = {rem[30:0], quo[31]}.
//   DIV_CMP, with alu_gnt=1:
//    - Drive alu_a=trial, alu_b=dvs, alu_op=1001.
//    - lt<=alu_res[0], except that rem[31]=1 forces lt<=0 (33-bit trial >= dvs).
//    - Go to DIV_SUB.
//   DIV_SUB, with alu_gnt=1:
//    - Drive alu_a=trial, alu_b=dvs, alu_op=0110.
//    - rem<=lt ? trial : alu_res; quo<={quo[30:0], ~lt}; cnt++.
//    - After cnt==31 -> DONE, else -> DIV_CMP. 64 granted cycles in total.
//  alu_gnt=0 in any compute state:
//   - No register changes; alu_req and the ALU outputs stay stable.
//   - Latency stretches by one cycle per stalled cycle.
//  DONE (one cycle):
//   - done=1; result<= acc (MUL), quo (DIVU) or rem (REMU).
//   - Then IDLE. busy=0 in DONE.
//   - start in DONE is ignored; the earliest re-accept is the next cycle.
//  Latency with no stalls, counted from the accept edge to done:
//   - MUL 33 cycles; DIVU/REMU 65 cycles.
//   - Divide-by-zero and reserved op: 1 cycle.
//  rst mid-operation aborts immediately to the reset state. No done pulse;
//  result clears to 0.
// TESTING
//  - MUL 7 x 6, gnt=1 -> done 33 cycles after accept, result=42; alu_op=0010 throughout.
//  - MUL 0xFFFFFFFF x 0xFFFFFFFF -> result=0x00000001; 0x10000 x 0x10000 -> 0.
//  - DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0xFFFFFFFF/0x80000001 -> 1, REMU -> 0x7FFFFFFE (rem[31] path).
//  - DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, 1-cycle done, alu_req never high.
//  - MUL 7x6 with alu_gnt=0 for cycles 10-14 -> done at 38, result=42; start pulses while busy ignored.
//  - rst at cycle 20 of DIVU -> busy=done=0, result=0 at once; next start runs normally.

Source files
------------

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle MUL / DIVU / REMU sequencer that borrows the shared core ALU
// through a req/gnt handshake and issues one ALU operation per granted cycle.
module alu_muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res
);

  localparam int unsigned CNT_W = 5;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV_CMP,
    S_DIV_SUB,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] mcand, mcand_n;
  logic [WIDTH-1:0] mplier, mplier_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic [WIDTH-1:0] quo, quo_n;
  logic [WIDTH-1:0] dvs, dvs_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             lt, lt_n;
  logic [1:0]       op_q, op_n;
  logic [WIDTH-1:0] result_n;
  logic [WIDTH-1:0] trial, trial_n;
  logic [WIDTH-1:0] alu_a_n, alu_b_n;
  logic [3:0]       alu_op_n;
  logic             busy_n, done_n;

  // Next-state, datapath update and next values of the registered outputs
  always_comb begin
    state_n  = state;
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    rem_n    = rem;
    quo_n    = quo;
    dvs_n    = dvs;
    cnt_n    = cnt;
    lt_n     = lt;
    op_n     = op_q;
    result_n = result;
    alu_a_n  = '0;
    alu_b_n  = '0;
    alu_op_n = ALU_ADD;
    trial    = {rem[WIDTH-2:0], quo[WIDTH-1]};

    case (state)
      S_IDLE: begin
        if (start) begin
          op_n  = op;
          cnt_n = '0;
          case (op)
            OP_MUL: begin
              acc_n    = '0;
              mcand_n  = opa;
              mplier_n = opb;
              state_n  = S_MUL;
            end
            OP_DIVU, OP_REMU: begin
              if (opb != '0) begin
                rem_n   = '0;
                quo_n   = opa;
                dvs_n   = opb;
                state_n = S_DIV_CMP;
              end else begin
                // Divide by zero: quotient all ones, remainder is the dividend
                rem_n   = opa;
                quo_n   = '1;
                state_n = S_DONE;
              end
            end
            default: begin
              acc_n   = '0;
              state_n = S_DONE;
            end
          endcase
        end
      end
      S_MUL: begin
        if (alu_gnt) begin
          if (mplier[0]) acc_n = alu_res;
          mcand_n  = mcand << 1;
          mplier_n = mplier >> 1;
          cnt_n    = cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state_n = S_DONE;
        end
      end
      S_DIV_CMP: begin
        if (alu_gnt) begin
          // A set rem msb means the 33-bit trial always exceeds the divisor
          lt_n    = rem[WIDTH-1] ? 1'b0 : alu_res[0];
          state_n = S_DIV_SUB;
        end
      end
      S_DIV_SUB: begin
        if (alu_gnt) begin
          rem_n   = lt ? trial : alu_res;
          quo_n   = {quo[WIDTH-2:0], ~lt};
          cnt_n   = cnt + CNT_W'(1);
          state_n = (cnt == CNT_W'(WIDTH - 1)) ? S_DONE : S_DIV_CMP;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (state_n == S_DONE) begin
      case (op_n)
        OP_MUL:  result_n = acc_n;
        OP_DIVU: result_n = quo_n;
        OP_REMU: result_n = rem_n;
        default: result_n = '0;
      endcase
    end

    trial_n = {rem_n[WIDTH-2:0], quo_n[WIDTH-1]};
    case (state_n)
      S_MUL: begin
        alu_a_n  = acc_n;
        alu_b_n  = mcand_n;
        alu_op_n = ALU_ADD;
      end
      S_DIV_CMP: begin
        alu_a_n  = trial_n;
        alu_b_n  = dvs_n;
        alu_op_n = ALU_SLTU;
      end
      S_DIV_SUB: begin
        alu_a_n  = trial_n;
        alu_b_n  = dvs_n;
        alu_op_n = ALU_SUB;
      end
      default: begin
        alu_a_n  = '0;
        alu_b_n  = '0;
        alu_op_n = ALU_ADD;
      end
    endcase

    busy_n = (state_n == S_MUL) || (state_n == S_DIV_CMP) || (state_n == S_DIV_SUB);
    done_n = (state_n == S_DONE);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      lt      <= 1'b0;
      op_q    <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      alu_req <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= ALU_ADD;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      mcand   <= mcand_n;
      mplier  <= mplier_n;
      rem     <= rem_n;
      quo     <= quo_n;
      dvs     <= dvs_n;
      cnt     <= cnt_n;
      lt      <= lt_n;
      op_q    <= op_n;
      result  <= result_n;
      busy    <= busy_n;
      done    <= done_n;
      alu_req <= busy_n;
      alu_a   <= alu_a_n;
      alu_b   <= alu_b_n;
      alu_op  <= alu_op_n;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Scoreboard bench for alu_muldiv_sequencer with a behavioural shared ALU.
module tb_alu_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa, opb;
  logic        busy, done;
  logic [31:0] result;
  logic        alu_req, alu_gnt;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;

  alu_muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_res(alu_res)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU model
  always_comb begin
    case (alu_op)
      4'b0010: alu_res = alu_a + alu_b;
      4'b0110: alu_res = alu_a - alu_b;
      4'b1001: alu_res = {31'b0, (alu_a < alu_b)};
      default: alu_res = 32'h0;
    endcase
  end

  typedef struct {
    logic [31:0] res;
    int unsigned lat;
    int unsigned acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse, checks idle ALU outputs
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!alu_req) begin
          chk("alu_idle_op", 32'(alu_op), 32'h2);
          chk("alu_idle_ab", alu_a | alu_b, 32'h0);
        end
        if (done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got result %h expected no done", result);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_result"}, result, e.res);
            chk({e.name, "_latency"}, cyc - e.acc, e.lat);
          end
        end
      end
    end
  end

  bit saw_req, bad_op;

  // Issue one operation at a negedge and follow it until done (or reset abort)
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int unsigned lat, input bit stall, input bit poke,
                        input int unsigned rst_at, output bit req_seen, output bit op_bad);
    int unsigned acc;
    int unsigned rel;
    bit finished;
    op = o; opa = a; opb = b; start = 1'b1;
    acc = cyc;
    sb.push_back('{exp_res, lat, acc, name});
    req_seen = 1'b0;
    op_bad = 1'b0;
    finished = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rel = cyc - acc;
      start = poke && (rel == 5 || rel == 20);
      if (start) begin
        op = 2'b10; opa = $urandom; opb = 32'd3;
      end
      alu_gnt = !(stall && rel >= 10 && rel <= 14);
      if (alu_req) req_seen = 1'b1;
      if (alu_req && o == 2'b00 && alu_op != 4'b0010) op_bad = 1'b1;
      if (rst_at != 0 && rel == rst_at) begin
        rst = 1'b1;
        #1;
        chk({name, "_abort_busy"}, 32'(busy), 32'h0);
        chk({name, "_abort_done"}, 32'(done), 32'h0);
        chk({name, "_abort_req"}, 32'(alu_req), 32'h0);
        chk({name, "_abort_result"}, result, 32'h0);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        finished = 1'b1;
        break;
      end
      if (done) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 300 cycles", name);
    end
    start = 1'b0;
    alu_gnt = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; alu_gnt = 1'b1; op = 2'b00; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_req", 32'(alu_req), 32'h0);
    chk("reset_result", result, 32'h0);
    chk("reset_alu_op", 32'(alu_op), 32'h2);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'd42, 33, 0, 0, 0, saw_req, bad_op);
    chk("mul_7x6_aluop_add", 32'(bad_op), 32'h0);
    chk("mul_7x6_req_seen", 32'(saw_req), 32'h1);
    run_op("mul_ones", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 33, 0, 0, 0, saw_req, bad_op);
    run_op("mul_wrap", 2'b00, 32'h10000, 32'h10000, 32'h0, 33, 0, 0, 0, saw_req, bad_op);
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 65, 0, 0, 0, saw_req, bad_op);
    run_op("remu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 65, 0, 0, 0, saw_req, bad_op);
    run_op("divu_big", 2'b01, 32'hFFFFFFFF, 32'h80000001, 32'h1, 65, 0, 0, 0, saw_req, bad_op);
    run_op("remu_big", 2'b10, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 65, 0, 0, 0, saw_req, bad_op);
    run_op("divu_by0", 2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0, 0, 0, saw_req, bad_op);
    chk("divu_by0_no_req", 32'(saw_req), 32'h0);
    run_op("remu_by0", 2'b10, 32'd5, 32'd0, 32'd5, 1, 0, 0, 0, saw_req, bad_op);
    chk("remu_by0_no_req", 32'(saw_req), 32'h0);
    run_op("reserved", 2'b11, 32'd9, 32'd9, 32'd0, 1, 0, 0, 0, saw_req, bad_op);
    run_op("mul_stall", 2'b00, 32'd7, 32'd6, 32'd42, 38, 1, 1, 0, saw_req, bad_op);
    chk("mul_stall_aluop_add", 32'(bad_op), 32'h0);
    chk("result_held", result, 32'd42);
    run_op("divu_rst", 2'b01, 32'd100, 32'd7, 32'd14, 65, 0, 0, 20, saw_req, bad_op);
    run_op("divu_after_rst", 2'b01, 32'd100, 32'd7, 32'd14, 65, 0, 0, 0, saw_req, bad_op);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
